rgb_to_ycbcr_front_end: RTL and testbench
=========================================

Name: rgb_to_ycbcr_front_end

Overview:
Front-end stage that feeds the Y-channel histogram equalizer.
- Takes raw RGB888 video with DE/HSYNC/VSYNC timing and converts it to full-range BT.601 YCbCr through a 3-stage pipeline.
- Generates per-pixel active-area coordinates x/y aligned with the converted data.
- Y plus coordinates plus pixel_valid drive the equalizer. Cb/Cr and delayed syncs are forwarded downstream for recombination.

Parameters:
H_ACTIVE, 640, active pixels per line; also the x range.
V_ACTIVE, 480, active lines per frame; also the y range.
VSYNC_POL, 1, active level of vsync_in (1 = active-high).

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
de_in  input  1  data enable; high during active pixels
hsync_in  input  1  horizontal sync; delayed only, not interpreted
vsync_in  input  1  vertical sync, polarity per VSYNC_POL
rgb_in  input  24  {R[23:16], G[15:8], B[7:0]}
pixel_valid_out  output  1  converted pixel valid with in-range coordinates
x_out  output  10  column of current output pixel, 0..H_ACTIVE-1
y_out  output  10  row of current output pixel, 0..V_ACTIVE-1
y_data_out  output  8  luma
cb_out  output  8  blue-difference chroma
cr_out  output  8  red-difference chroma
hsync_out  output  1  hsync_in delayed 3 cycles
vsync_out  output  1  vsync_in delayed 3 cycles
overflow_flag  output  1  sticky; set by an out-of-range pixel, cleared at frame start

Behaviour:
Reset
- On rst_n low, all outputs and pipeline registers clear to 0 asynchronously, and counters clear.
- The synced flag also clears to 0.

Frame start
- A frame starts on the cycle vsync_in transitions to its active level.
- At frame start: x_cnt=0, y_cnt=0, overflow_flag=0, synced=1.
- Until the first frame start after reset, pixel_valid_out stays 0. Data, coordinates and syncs still flow.
- This prevents a mid-frame reset from producing misaligned coordinates.

Counters (input side)
- Each cycle with de_in=1: the pixel is tagged with (x_cnt, y_cnt), then x_cnt increments.
- On the cycle after de_in falls (de 1->0): x_cnt clears to 0 and y_cnt increments.
- y_cnt saturates at 1023. x_cnt saturates at 1023.

Validity tag
- tag = de_in && synced && x_cnt < H_ACTIVE && y_cnt < V_ACTIVE.
- A de_in=1 pixel that fails the range test has tag=0 and sets overflow_flag on that cycle.
- Simultaneous frame start and de_in=1: the pixel is tagged (0,0), and frame start wins over the overflow clear/set.

Conversion (signed arithmetic, width at least 18 bits)
- Y  = (77R + 150G + 29B + 128) >>> 8
- Cb = ((-43R - 85G + 128B + 128) >>> 8) + 128
- Cr = ((128R - 107G - 21B + 128) >>> 8) + 128
- >>> is an arithmetic (floor) shift.
- Each result is clamped to 0..255.

Pipeline
- S1: register inputs and the nine products.
- S2: sum each channel plus the rounding constant.
- S3: shift, offset and clamp into the output registers.
- Latency is exactly 3 cycles from input to output for every signal: data, x/y, tag->pixel_valid_out, hsync, vsync.
- No backpressure; one pixel per clock sustained.
- When pixel_valid_out=0, data outputs carry whatever the pipeline computed and x_out/y_out carry the delayed counters. Consumers must ignore them.

Test Plan:
1. Reset, then drive 3 cycles of de with no preceding vsync -> pixel_valid_out stays 0. Then drive a vsync pulse plus a line -> first valid output at x_out=0, y_out=0, exactly 3 cycles after its input.
2. Pixel colour checks:
   - RGB=FFFFFF -> Y=255, Cb=128, Cr=128.
   - RGB=FF0000 -> Y=77, Cb=85, Cr=255 (Cr clamped).
   - RGB=000000 -> Y=0, Cb=128, Cr=128.
3. Full 640x480 frame with blanking -> exactly 307200 valid pixels. The last valid pixel has x_out=639 and y_out=479, asserted together. overflow_flag stays 0.
4. Line with 642 de cycles -> pixels 640 and 641 have pixel_valid_out=0 and overflow_flag sets. The next vsync active edge clears overflow_flag.
5. Assert rst_n low mid-line -> all outputs are 0 immediately, without waiting for clk. After release, no valid output appears until the next vsync. The following frame then counts from (0,0).
6. Run with VSYNC_POL=0 and an active-low vsync -> identical coordinate and valid behaviour. vsync_out/hsync_out equal the inputs delayed by 3 cycles.

Source files
------------

// File: rtl/rgb_to_ycbcr_front_end.sv
// RGB888 -> full-range BT.601 YCbCr front end for the luma histogram equalizer.
// Three-stage conversion pipeline with active-area coordinates and syncs kept in step.

module ycc_chan #(
  parameter int KR  = 0,
  parameter int KG  = 0,
  parameter int KB  = 0,
  parameter int OFS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [7:0] q
);
  logic signed [19:0] pr, pg, pb, sum, t;

  // floor shift, then offset; clamp happens on the way into q
  assign t = (sum >>> 8) + 20'(OFS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr  <= '0;
      pg  <= '0;
      pb  <= '0;
      sum <= '0;
      q   <= '0;
    end else begin
      pr  <= 20'(KR * int'(r));
      pg  <= 20'(KG * int'(g));
      pb  <= 20'(KB * int'(b));
      sum <= pr + pg + pb + 20'sd128;
      if (t < 20'sd0)        q <= 8'd0;
      else if (t > 20'sd255) q <= 8'd255;
      else                   q <= t[7:0];
    end
  end
endmodule

module rgb_to_ycbcr_front_end #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] rgb_in,
  output logic        pixel_valid_out,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic [7:0]  y_data_out,
  output logic [7:0]  cb_out,
  output logic [7:0]  cr_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        overflow_flag
);
  localparam int         STAGES = 3;
  localparam logic       VPOL   = (VSYNC_POL != 0);
  localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
  localparam int KR_T  [3] = '{77, -43, 128};
  localparam int KG_T  [3] = '{150, -85, -107};
  localparam int KB_T  [3] = '{29, 128, -21};
  localparam int OFS_T [3] = '{0, 128, 128};

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
  } side_t;

  logic             vs_prev, de_prev, synced;
  logic [9:0]       x_cnt, y_cnt, tag_x, tag_y;
  logic             frame_start, in_range, tag;
  side_t            side_in;
  side_t            side_pipe [1:STAGES];
  logic [STAGES:1]  vld_pipe;
  logic [2:0][7:0]  ycc;

  assign frame_start = (vsync_in == VPOL) && (vs_prev != VPOL);
  // a pixel landing on frame start already belongs to the new frame at (0,0)
  assign tag_x    = frame_start ? 10'd0 : x_cnt;
  assign tag_y    = frame_start ? 10'd0 : y_cnt;
  assign in_range = (tag_x < H_LIM) && (tag_y < V_LIM);
  assign tag      = de_in && (synced || frame_start) && in_range;
  assign side_in  = '{x: tag_x, y: tag_y, hs: hsync_in, vs: vsync_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev       <= 1'b0;
      de_prev       <= 1'b0;
      synced        <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      overflow_flag <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      de_prev <= de_in;
      if (frame_start) begin
        x_cnt         <= de_in ? 10'd1 : 10'd0;
        y_cnt         <= '0;
        synced        <= 1'b1;
        overflow_flag <= 1'b0;
      end else begin
        if (de_in) begin
          if (x_cnt != 10'd1023) x_cnt <= x_cnt + 10'd1;
          if (!in_range) overflow_flag <= 1'b1;
        end else if (de_prev) begin
          x_cnt <= '0;
          if (y_cnt != 10'd1023) y_cnt <= y_cnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) side_pipe[s] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:1], tag};
      side_pipe[1] <= side_in;
      for (int s = 2; s <= STAGES; s++) side_pipe[s] <= side_pipe[s-1];
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    ycc_chan #(.KR(KR_T[c]), .KG(KG_T[c]), .KB(KB_T[c]), .OFS(OFS_T[c])) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .r     (rgb_in[23:16]),
      .g     (rgb_in[15:8]),
      .b     (rgb_in[7:0]),
      .q     (ycc[c])
    );
  end

  assign pixel_valid_out = vld_pipe[STAGES];
  assign x_out           = side_pipe[STAGES].x;
  assign y_out           = side_pipe[STAGES].y;
  assign hsync_out       = side_pipe[STAGES].hs;
  assign vsync_out       = side_pipe[STAGES].vs;
  assign y_data_out      = ycc[0];
  assign cb_out          = ycc[1];
  assign cr_out          = ycc[2];
endmodule

// File: tb/tb_rgb_to_ycbcr_front_end.sv
// Directed bench: two small-geometry instances (active-high and active-low vsync) driven in lockstep.
module tb_rgb_to_ycbcr_front_end;
  localparam int H = 16;
  localparam int V = 8;

  logic clk = 0, rst_n = 0;
  logic de = 0, hs = 0, vs = 0;
  logic [23:0] rgb = '0;
  logic vs_n;
  assign vs_n = ~vs;

  logic pv, hso, vso, ovf, pv_n, hso_n, vso_n, ovf_n;
  logic [9:0] xo, yo, xo_n, yo_n;
  logic [7:0] yd, cb, cr, yd_n, cb_n, cr_n;

  int vecs = 0, errs = 0;
  int valid_cnt = 0;
  int last_x = -1, last_y = -1;

  logic [23:0] tbl   [7] = '{24'hFFFFFF, 24'hFF0000, 24'h000000, 24'h00FF00, 24'h0000FF, 24'h808080, 24'h000000};
  logic [7:0]  exp_y [7] = '{8'd255, 8'd77,  8'd0,   8'd149, 8'd29,  8'd128, 8'd0};
  logic [7:0]  exp_cb[7] = '{8'd128, 8'd85,  8'd128, 8'd43,  8'd255, 8'd128, 8'd128};
  logic [7:0]  exp_cr[7] = '{8'd128, 8'd255, 8'd128, 8'd21,  8'd107, 8'd128, 8'd128};

  always #5 clk = ~clk;

  rgb_to_ycbcr_front_end #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de), .hsync_in(hs), .vsync_in(vs), .rgb_in(rgb),
    .pixel_valid_out(pv), .x_out(xo), .y_out(yo), .y_data_out(yd), .cb_out(cb), .cr_out(cr),
    .hsync_out(hso), .vsync_out(vso), .overflow_flag(ovf));

  rgb_to_ycbcr_front_end #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .de_in(de), .hsync_in(hs), .vsync_in(vs_n), .rgb_in(rgb),
    .pixel_valid_out(pv_n), .x_out(xo_n), .y_out(yo_n), .y_data_out(yd_n), .cb_out(cb_n), .cr_out(cr_n),
    .hsync_out(hso_n), .vsync_out(vso_n), .overflow_flag(ovf_n));

  task automatic cyc(input logic d, input logic h, input logic v, input logic [23:0] c);
    @(negedge clk);
    de = d; hs = h; vs = v; rgb = c;
  endtask

  task automatic vsync_pulse();
    cyc(0, 0, 1, 24'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 24'h0);
  endtask

  // drives n_de pixels then 3 blank cycles; the output seen at step i belongs to input i-3
  task automatic run_line(input int n_de, input int line_y, input bit sync);
    logic hsh [64];
    for (int i = 0; i < n_de + 3; i++) begin
      hsh[i] = (i % 4 == 1);
      cyc(i < n_de, hsh[i], 0, (i < n_de) ? tbl[(i < 6) ? i : 6] : 24'h0);
      if (i >= 3) begin
        int j;
        logic e_pv;
        j = i - 3;
        e_pv = sync && (j < H) && (line_y < V);
        vecs++;
        if (pv !== e_pv || pv_n !== e_pv) begin
          errs++;
          $display("FAIL valid line %0d px %0d: got %b/%b want %b", line_y, j, pv, pv_n, e_pv);
        end
        vecs++;
        if (xo !== 10'(j) || yo !== 10'(line_y) || xo_n !== 10'(j) || yo_n !== 10'(line_y)) begin
          errs++;
          $display("FAIL coord line %0d px %0d: got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)",
                   line_y, j, xo, yo, xo_n, yo_n, j, line_y);
        end
        vecs++;
        if (yd !== exp_y[(j < 6) ? j : 6] || cb !== exp_cb[(j < 6) ? j : 6] || cr !== exp_cr[(j < 6) ? j : 6]) begin
          errs++;
          $display("FAIL colour px %0d: got %0d/%0d/%0d want %0d/%0d/%0d", j, yd, cb, cr,
                   exp_y[(j < 6) ? j : 6], exp_cb[(j < 6) ? j : 6], exp_cr[(j < 6) ? j : 6]);
        end
        vecs++;
        if (hso !== hsh[j] || hso_n !== hsh[j] || vso !== 1'b0 || vso_n !== 1'b1) begin
          errs++;
          $display("FAIL sync delay px %0d: got hs %b/%b vs %b/%b want hs %b vs 0/1", j, hso, hso_n, vso, vso_n, hsh[j]);
        end
        if (pv) begin
          valid_cnt++;
          last_x = int'(xo);
          last_y = int'(yo);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc(0, 0, 0, 24'h0);
    cyc(0, 0, 0, 24'h0);
    vecs++;
    if ({pv, xo, yo, yd, cb, cr, hso, vso, ovf} !== '0 || {pv_n, xo_n, yo_n, yd_n, cb_n, cr_n, hso_n, vso_n, ovf_n} !== '0) begin
      errs++;
      $display("FAIL reset state: outputs not all zero (x=%0d y=%0d cb=%0d)", xo, yo, cb);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_unsynced();
    for (int i = 0; i < 6; i++) begin
      cyc(i < 3, 0, 0, 24'hFFFFFF);
      vecs++;
      if (pv !== 1'b0 || pv_n !== 1'b0) begin
        errs++;
        $display("FAIL unsynced valid cycle %0d: got %b/%b want 0", i, pv, pv_n);
      end
    end
  endtask

  task automatic test_first_pixel();
    vsync_pulse();
    cyc(1, 0, 0, tbl[0]);
    cyc(1, 0, 0, tbl[1]);
    cyc(1, 0, 0, tbl[2]);
    vecs++;
    if (pv !== 1'b0) begin
      errs++;
      $display("FAIL latency early: valid %b want 0", pv);
    end
    cyc(0, 0, 0, 24'h0);
    vecs++;
    if (pv !== 1'b1 || xo !== 10'd0 || yo !== 10'd0 || yd !== 8'd255) begin
      errs++;
      $display("FAIL first pixel: got v=%b (%0d,%0d) y=%0d want v=1 (0,0) y=255", pv, xo, yo, yd);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 24'h0);
  endtask

  task automatic test_frame();
    vsync_pulse();
    valid_cnt = 0;
    for (int l = 0; l < V; l++) run_line(H, l, 1);
    vecs++;
    if (valid_cnt != H * V) begin
      errs++;
      $display("FAIL frame count: got %0d want %0d", valid_cnt, H * V);
    end
    vecs++;
    if (last_x != H - 1 || last_y != V - 1) begin
      errs++;
      $display("FAIL last pixel: got (%0d,%0d) want (%0d,%0d)", last_x, last_y, H - 1, V - 1);
    end
    vecs++;
    if (ovf !== 1'b0 || ovf_n !== 1'b0) begin
      errs++;
      $display("FAIL frame overflow: got %b/%b want 0", ovf, ovf_n);
    end
    // one line past the active height: every pixel untagged, overflow raised
    run_line(H, V, 1);
    vecs++;
    if (ovf !== 1'b1) begin
      errs++;
      $display("FAIL row overflow: got %b want 1", ovf);
    end
  endtask

  task automatic test_overflow();
    vsync_pulse();
    vecs++;
    if (ovf !== 1'b0) begin
      errs++;
      $display("FAIL overflow clear after frame start: got %b want 0", ovf);
    end
    run_line(H + 2, 0, 1);
    vecs++;
    if (ovf !== 1'b1 || ovf_n !== 1'b1) begin
      errs++;
      $display("FAIL long line overflow: got %b/%b want 1", ovf, ovf_n);
    end
    run_line(H, 1, 1);
    vecs++;
    if (ovf !== 1'b1) begin
      errs++;
      $display("FAIL overflow sticky: got %b want 1", ovf);
    end
    cyc(0, 0, 1, 24'h0);
    cyc(0, 0, 0, 24'h0);
    vecs++;
    if (ovf !== 1'b0 || ovf_n !== 1'b0) begin
      errs++;
      $display("FAIL overflow clear on vsync: got %b/%b want 0", ovf, ovf_n);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 24'h0);
  endtask

  task automatic test_mid_reset();
    vsync_pulse();
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, tbl[1]);
    #2 rst_n = 0;
    #1;
    vecs++;
    if ({pv, xo, yo, yd, cb, cr, hso, vso, ovf} !== '0 || {pv_n, xo_n, yo_n, yd_n, cb_n, cr_n, hso_n, vso_n, ovf_n} !== '0) begin
      errs++;
      $display("FAIL async reset: got v=%b x=%0d y=%0d yd=%0d cr=%0d want all 0", pv, xo, yo, yd, cr);
    end
    cyc(0, 0, 0, 24'h0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 24'h0);
    run_line(H, 0, 0);
    vsync_pulse();
    run_line(H, 0, 1);
    run_line(H, 1, 1);
  endtask

  task automatic test_sync_delay();
    logic hh [16];
    logic vh [16];
    for (int i = 0; i < 16; i++) begin
      hh[i] = (i % 3 == 0);
      vh[i] = (i >= 5 && i < 9);
      cyc(0, hh[i], vh[i], 24'h0);
      if (i >= 3) begin
        vecs++;
        if (hso !== hh[i-3] || vso !== vh[i-3] || hso_n !== hh[i-3] || vso_n !== ~vh[i-3]) begin
          errs++;
          $display("FAIL sync pipe step %0d: got hs %b/%b vs %b/%b want hs %b vs %b/%b",
                   i, hso, hso_n, vso, vso_n, hh[i-3], vh[i-3], ~vh[i-3]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unsynced();
    test_first_pixel();
    test_frame();
    test_overflow();
    test_mid_reset();
    test_sync_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
